// File: rtl/rb_link_pkg.sv
// Shared definitions for the RB1->RB2 serial link (transmitter and S2 receiver).
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Frame layout on the wire, first bit first:
//   A[ADDR_W-1] .. A[0], D[DATA_W-1] .. D[0]
// In other words, the frame word is {addr, data} sent MSB first.
package rb_link_pkg;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 18;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int N_WORDS = 8;

  // ST_ prefix keeps the GAP state distinct from the GAP length parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  // Frame word whose MSB is transmitted first.
  function automatic logic [FRAME_W-1:0] frame_pack(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/frame_piso.sv
// Parallel-load, MSB-first shift register with a bit counter for one link frame.
// Latency: sd shows din[W-1] the cycle after load; one further bit per shift.
// Backpressure: none; the controller decides when to load and shift.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture din and clear the bit counter (wins over shift)
//   shift      move to the next bit; zeros fill from the bottom
//   din[W]     frame word, MSB sent first
//   sd         current serial bit (MSB of the register)
//   last       the bit currently on sd is the final bit of the frame
module frame_piso #(
  parameter int W = rb_link_pkg::FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sd,
  output logic         last
);

  // Counter reaches W after the final shift, so it needs room for W.
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     shift_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= din;
      cnt_q   <= '0;
    end else if (shift) begin
      // Zero fill leaves the register empty once the frame is out, so sd
      // idles low without extra gating.
      shift_q <= {shift_q[W-2:0], 1'b0};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign sd   = shift_q[W-1];
  assign last = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/rb_serial_tx_ctrl.sv
// Walks RB1 words 0..N_WORDS-1 and serialises each as an {addr,data} frame on sen/sd.
// Latency: first sen low 2 cycles after start; 2+FRAME+GAP cycles per word.
// Backpressure: none; start is ignored unless IDLE or DONE.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      one-cycle run request (accepted in IDLE or DONE)
//   busy       run in progress (FETCH of word 0 until DONE)
//   done       run complete, held until the next start
//   RB1_RW     RB1 read/write select, permanently read (1)
//   RB1_A      RB1 read address
//   RB1_Q      RB1 read data, one cycle after RB1_A
//   sen        frame enable, active low, low for ADDR_W+DATA_W cycles per frame
//   sd         serial data, meaningful while sen is low, 0 otherwise
module rb_serial_tx_ctrl #(
  parameter int ADDR_W  = rb_link_pkg::ADDR_W,
  parameter int DATA_W  = rb_link_pkg::DATA_W,
  parameter int N_WORDS = rb_link_pkg::N_WORDS,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              RB1_RW,
  output logic [ADDR_W-1:0] RB1_A,
  input  logic [DATA_W-1:0] RB1_Q,
  output logic              sen,
  output logic              sd
);

  import rb_link_pkg::*;

  localparam int FW    = ADDR_W + DATA_W;
  localparam int GAP_W = $clog2(GAP + 1);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q, idx_nxt;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_nxt;
  logic              piso_load, piso_shift, piso_last, piso_sd;

  logic              sen_q, busy_q, done_q;
  logic [ADDR_W-1:0] rb1_a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    gap_cnt_nxt = '0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        // RB1_Q now reflects the address presented during FETCH.
        piso_load = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        piso_shift = 1'b1;
        if (piso_last) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          if (idx_q == ADDR_W'(N_WORDS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_FETCH;
            idx_nxt   = idx_q + ADDR_W'(1);
          end
        end else begin
          gap_cnt_nxt = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe rather than trailing it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      gap_cnt_q <= '0;
      sen_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rb1_a_q   <= '0;
    end else begin
      idx_q     <= idx_nxt;
      gap_cnt_q <= gap_cnt_nxt;
      sen_q     <= (state_nxt != ST_SEND);
      busy_q    <= (state_nxt == ST_FETCH) || (state_nxt == ST_LOAD) ||
                   (state_nxt == ST_SEND)  || (state_nxt == ST_GAP);
      done_q    <= (state_nxt == ST_DONE);
      if (state_nxt == ST_FETCH) rb1_a_q <= idx_nxt;
    end
  end

  frame_piso #(
    .W(FW)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (piso_load),
    .shift(piso_shift),
    .din  ({idx_q, RB1_Q}),
    .sd   (piso_sd),
    .last (piso_last)
  );

  assign RB1_RW = 1'b1;
  assign RB1_A  = rb1_a_q;
  assign sen    = sen_q;
  assign sd     = piso_sd;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rb_serial_tx_ctrl.sv
// Directed-plus-random bench for rb_serial_tx_ctrl with an RB1 memory and a frame receiver.
// Latency: expected waveform derived per cycle from word period arithmetic.
// Backpressure: n/a.
module tb_rb_serial_tx_ctrl;

  localparam int AW  = 3;
  localparam int DW  = 18;
  localparam int NW  = 8;
  localparam int GP  = 2;
  localparam int FW  = AW + DW;
  localparam int PER = 2 + FW + GP;
  localparam int RUN = NW * PER;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rb1_rw, sen, sd;
  logic [AW-1:0] rb1_a;
  logic [DW-1:0] rb1_q;

  logic [DW-1:0] rb1 [NW];
  logic [DW-1:0] rb2 [NW];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // RB1 with one-cycle synchronous read.
  always @(posedge clk) rb1_q <= rb1[rb1_a];

  rb_serial_tx_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .N_WORDS(NW),
    .GAP    (GP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .RB1_RW(rb1_rw),
    .RB1_A (rb1_a),
    .RB1_Q (rb1_q),
    .sen   (sen),
    .sd    (sd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit b (0 = first on the wire) of the frame for word w.
  function automatic logic exp_bit(input int w, input int b);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'(w);
    d = rb1[w];
    if (b < AW) return a[AW-1-b];
    return d[DW-1-(b-AW)];
  endfunction

  // Called at a negedge. Pulses start, then checks every cycle of the run.
  // extra_c: cycle at which a stray start is raised (-1 none).
  // rst_c:   cycle at which reset is asserted mid-cycle and the run abandoned (-1 none).
  task automatic run(input string tag, input int extra_c, input int rst_c);
    logic [FW-1:0] rx;
    int            nrx;
    int            w, k;
    logic [3:0]    exp_v;
    for (int i = 0; i < NW; i++) rb2[i] = 'x;
    rx  = '0;
    nrx = 0;
    start = 1'b1;
    for (int c = 0; c <= RUN; c++) begin
      @(negedge clk);
      start = 1'b0;
      w = c / PER;
      k = c % PER;
      if (c == RUN)                  exp_v = 4'b1001;
      else if (k >= 2 && k < 2 + FW) exp_v = {1'b0, exp_bit(w, k - 2), 2'b10};
      else                           exp_v = 4'b1010;
      chk($sformatf("%s c%0d sen,sd,busy,done", tag, c), {28'b0, sen, sd, busy, done}, {28'b0, exp_v});
      if (c < RUN && k < 2) chk($sformatf("%s c%0d RB1_A", tag, c), {29'b0, rb1_a}, w);
      if (sen === 1'b0) begin
        rx = {rx[FW-2:0], sd};
        nrx++;
        if (nrx == FW) begin
          rb2[rx[FW-1:DW]] = rx[DW-1:0];
          nrx = 0;
        end
      end
      if (c == extra_c) start = 1'b1;
      if (c == rst_c) begin
        #2 rst = 1'b1;
        #1 chk({tag, " async reset outputs"}, {28'b0, sen, sd, busy, done}, 32'b1000);
        return;
      end
    end
    for (int i = 0; i < NW; i++) chk($sformatf("%s rb2[%0d]", tag, i), {14'b0, rb2[i]}, {14'b0, rb1[i]});
    chk({tag, " RB1_RW"}, {31'b0, rb1_rw}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) rb1[i] = '0;

    // Reset with start held high: must be ignored.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset sen,sd,busy,done", {28'b0, sen, sd, busy, done}, 32'b1000);
    chk("reset RB1_A", {29'b0, rb1_a}, 32'd0);
    chk("reset RB1_RW", {31'b0, rb1_rw}, 32'd1);
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d sen,sd,busy,done", c), {28'b0, sen, sd, busy, done}, 32'b1000);
    end

    // Incrementing pattern.
    for (int i = 0; i < NW; i++) rb1[i] = 18'h3_0000 + DW'(i);
    run("inc", -1, -1);

    // Alternating bit patterns.
    for (int i = 0; i < NW; i++) rb1[i] = (i % 2 == 0) ? 18'h2AAAA : 18'h15555;
    run("alt", -1, -1);

    // Random data, stray start during frame 3, then a repeat run from DONE.
    for (int i = 0; i < NW; i++) rb1[i] = DW'($urandom);
    run("rnd_stray", 3 * PER + 10, -1);
    repeat (5) begin
      @(negedge clk);
      chk("hold in DONE", {30'b0, busy, done}, 32'b01);
    end
    run("rnd_again", -1, -1);

    // Reset at bit 10 of frame 5, then a fresh run from word 0.
    for (int i = 0; i < NW; i++) rb1[i] = DW'($urandom);
    run("rst_mid", -1, 5 * PER + 2 + 10);
    repeat (2) begin
      @(negedge clk);
      chk("in reset", {28'b0, sen, sd, busy, done}, 32'b1000);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("after reset idle", {28'b0, sen, sd, busy, done}, 32'b1000);
    for (int i = 0; i < NW; i++) rb1[i] = DW'($urandom);
    run("post_rst", -1, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
